// File: rtl/rd_responder.sv
// rtl/rd_responder.sv - single-strobe read responder with wait-state retry, timeout and status register
module rd_responder #(
    parameter int            DW       = 8,
    parameter int            MAX_WAIT = 4,
    parameter logic [DW-1:0] FILL     = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic          rs,
    output logic          ws,
    output logic [DW-1:0] rdata,
    output logic          rerr,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready
);
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    state_t        state;
    logic [7:0]    wait_cnt;
    logic [5:0]    timeout_cnt;
    logic          proto_err;
    logic [DW-1:0] status_word;
    logic          accept;

    assign accept    = rd && (state == IDLE);
    assign src_ready = accept & ~rs & src_valid & rst_n;

    always_comb begin
        status_word      = '0;
        status_word[7:0] = {src_valid, proto_err, timeout_cnt};
    end

    // Response outputs default low every edge so they only live for the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ws          <= 1'b0;
            rerr        <= 1'b0;
            rdata       <= '0;
            wait_cnt    <= 8'd0;
            timeout_cnt <= 6'd0;
            proto_err   <= 1'b0;
        end else begin
            ws   <= 1'b0;
            rerr <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd) begin
                        state <= RESP;
                        if (rs) begin
                            rdata     <= status_word;
                            proto_err <= 1'b0;
                        end else if (src_valid) begin
                            rdata    <= src_data;
                            wait_cnt <= 8'd0;
                        end else if (wait_cnt < MAX_WAIT_L) begin
                            ws       <= 1'b1;
                            wait_cnt <= wait_cnt + 8'd1;
                        end else begin
                            rerr     <= 1'b1;
                            rdata    <= FILL;
                            wait_cnt <= 8'd0;
                            if (timeout_cnt != 6'd63)
                                timeout_cnt <= timeout_cnt + 6'd1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    // A strobe here is an initiator protocol violation: ignored but recorded.
                    if (rd)
                        proto_err <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rd_responder.sv
// tb/tb_rd_responder.sv - table-driven self-checking bench for rd_responder
module tb_rd_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd;
    logic       rs;
    logic       ws;
    logic [7:0] rdata;
    logic       rerr;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rd;
        logic       rs;
        logic       sv;
        logic [7:0] data;
        logic       sr;
        logic       ws;
        logic [7:0] rdata;
        logic       rerr;
    } vec_t;

    vec_t vecs[$];

    rd_responder #(.DW(8), .MAX_WAIT(4), .FILL(8'hFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .rs        (rs),
        .ws        (ws),
        .rdata     (rdata),
        .rerr      (rerr),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Inputs change at negedge; src_ready checked before the edge, registered outputs after it.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        rd = v.rd; rs = v.rs; src_valid = v.sv; src_data = v.data;
        #1;
        chk("src_ready", idx, 32'(src_ready), 32'(v.sr));
        @(posedge clk);
        #1;
        chk("ws", idx, 32'(ws), 32'(v.ws));
        chk("rdata", idx, 32'(rdata), 32'(v.rdata));
        chk("rerr", idx, 32'(rerr), 32'(v.rerr));
    endtask

    initial begin
        logic [7:0] cur;
        int n;

        rst_n = 1'b0; rd = 1'b1; rs = 1'b0; src_valid = 1'b1; src_data = 8'h11;
        #2;
        chk("reset_src_ready", 0, 32'(src_ready), 32'd0);
        @(posedge clk); #1;
        chk("reset_ws", 0, 32'(ws), 32'd0);
        chk("reset_rerr", 0, 32'(rerr), 32'd0);
        chk("reset_rdata", 0, 32'(rdata), 32'd0);
        @(negedge clk);
        rd = 1'b0; src_valid = 1'b0; rst_n = 1'b1;

        // immediate data, two retries then data, full timeout, status
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0});
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0});
            vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0});
        end
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0});

        foreach (vecs[i]) step(vecs[i], i);
        n = vecs.size();

        // 63 more timeouts drive timeout_cnt to 64 attempts, saturating at 63
        cur = 8'h01;
        for (int t = 0; t < 63; t++) begin
            for (int s = 0; s < 4; s++) begin
                step('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, cur, 1'b0}, n++);
                step('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur, 1'b0}, n++);
            end
            step('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1}, n++);
            cur = 8'hFF;
            step('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur, 1'b0}, n++);
        end
        step('{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 8'hBF, 1'b0}, n++);
        step('{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'hBF, 1'b0}, n++);

        // back-to-back strobes: second ignored, sticky proto_err then cleared by status read
        step('{1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h77, 1'b0}, n++);
        step('{1'b1, 1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 8'h77, 1'b0}, n++);
        step('{1'b0, 1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 8'h77, 1'b0}, n++);
        step('{1'b1, 1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 8'hFF, 1'b0}, n++);
        step('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0}, n++);
        step('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3F, 1'b0}, n++);
        step('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3F, 1'b0}, n++);

        // asynchronous reset in a ws=1 response cycle
        step('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3F, 1'b0}, n++);
        @(negedge clk);
        rst_n = 1'b0; rd = 1'b1; rs = 1'b0; src_valid = 1'b1; src_data = 8'h5A;
        #1;
        chk("midreset_ws", n, 32'(ws), 32'd0);
        chk("midreset_rerr", n, 32'(rerr), 32'd0);
        chk("midreset_rdata", n, 32'(rdata), 32'd0);
        chk("midreset_src_ready", n, 32'(src_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rd = 1'b0; src_valid = 1'b0;
        step('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}, n++);
        step('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}, n++);
        step('{1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0}, n++);
        step('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0}, n++);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
